// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - RV32I OP/OP-IMM decode and operand fetch with regfile, scoreboard and ALU skid register
// Holds one issued instruction toward the ALU; owns the register file write port and RAW scoreboard.
module decode_stage #(
   parameter int XLEN   = 32,
   parameter bit BYPASS = 1'b1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            instr_valid,
   input  logic [31:0]     instr,
   output logic            instr_ready,
   output logic            alu_valid,
   input  logic            alu_ready,
   output logic [2:0]      funct3,
   output logic [6:0]      funct7,
   output logic [XLEN-1:0] rs1_val,
   output logic [XLEN-1:0] rs2_val,
   output logic [4:0]      rd_addr,
   output logic            rd_we,
   input  logic            wb_en,
   input  logic [4:0]      wb_addr,
   input  logic [XLEN-1:0] wb_data,
   output logic            illegal
);

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

   logic [XLEN-1:0] regs [32];
   logic [31:0]     pending;

   logic [6:0]      opcode;
   logic [4:0]      rs1, rs2, rd;
   logic [2:0]      f3;
   logic            is_op, is_imm, legal;
   logic [31:0]     wb_hit;
   logic [31:0]     set_mask;
   logic [31:0]     pending_eff;
   logic            hazard, accept, issue;
   logic [XLEN-1:0] rs1_rd, rs2_rd;
   logic [XLEN-1:0] imm_sext, shamt_ext;
   logic [XLEN-1:0] op_b;
   logic [6:0]      f7_n;

   assign opcode = instr[6:0];
   assign rd     = instr[11:7];
   assign f3     = instr[14:12];
   assign rs1    = instr[19:15];
   assign rs2    = instr[24:20];
   assign is_op  = (opcode == OPC_OP);
   assign is_imm = (opcode == OPC_OP_IMM);
   assign legal  = is_op | is_imm;

   // One-hot of the register being written back this cycle; x0 never participates.
   always_comb begin
      wb_hit = '0;
      if (wb_en && (wb_addr != 5'd0)) begin
         wb_hit[wb_addr] = 1'b1;
      end
   end

   always_comb begin
      set_mask = '0;
      if (issue && (rd != 5'd0)) begin
         set_mask[rd] = 1'b1;
      end
   end

   // Without forwarding the operand read cannot see wb_data, so a clearing writeback only helps next cycle.
   assign pending_eff = BYPASS ? (pending & ~wb_hit) : pending;
   assign hazard      = pending_eff[rs1] | (is_op & pending_eff[rs2]);
   assign instr_ready = (!alu_valid || alu_ready) && !hazard;
   assign accept      = instr_valid && instr_ready;
   assign issue       = accept && legal;

   always_comb begin
      rs1_rd = regs[rs1];
      if (rs1 == 5'd0) begin
         rs1_rd = '0;
      end else if (BYPASS && wb_hit[rs1]) begin
         rs1_rd = wb_data;
      end
   end

   always_comb begin
      rs2_rd = regs[rs2];
      if (rs2 == 5'd0) begin
         rs2_rd = '0;
      end else if (BYPASS && wb_hit[rs2]) begin
         rs2_rd = wb_data;
      end
   end

   assign imm_sext  = {{(XLEN-12){instr[31]}}, instr[31:20]};
   assign shamt_ext = {{(XLEN-5){1'b0}}, instr[24:20]};

   // Shift-immediate forms carry a shift amount, and only the right shifts use funct7 to pick SRLI/SRAI.
   always_comb begin
      op_b = rs2_rd;
      f7_n = instr[31:25];
      if (!is_op) begin
         f7_n = (f3 == 3'b101) ? instr[31:25] : 7'd0;
         op_b = ((f3 == 3'b001) || (f3 == 3'b101)) ? shamt_ext : imm_sext;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         alu_valid <= 1'b0;
         illegal   <= 1'b0;
         funct3    <= '0;
         funct7    <= '0;
         rs1_val   <= '0;
         rs2_val   <= '0;
         rd_addr   <= '0;
         rd_we     <= 1'b0;
      end else begin
         illegal <= accept && !legal;
         if (issue) begin
            alu_valid <= 1'b1;
            funct3    <= f3;
            funct7    <= f7_n;
            rs1_val   <= rs1_rd;
            rs2_val   <= op_b;
            rd_addr   <= rd;
            rd_we     <= (rd != 5'd0);
         end else if (alu_ready) begin
            alu_valid <= 1'b0;
         end
      end
   end

   // A new reservation wins over a same-cycle writeback to the same register.
   always_ff @(posedge clk) begin
      if (rst) begin
         pending <= '0;
      end else begin
         pending <= (pending & ~wb_hit) | set_mask;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 32; i++) begin
            regs[i] <= '0;
         end
      end else if (wb_en && (wb_addr != 5'd0)) begin
         regs[wb_addr] <= wb_data;
      end
   end

endmodule
